// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream to instruction-memory word loader
// Optional trailer-byte checksum stage enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int MEM_DEPTH = 16384
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] base_addr,
   input  logic [15:0] word_count,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RECV  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam logic [1:0] CHECK = 2'd3;
`endif

   logic [1:0]  state;
   logic [1:0]  byte_idx;
   logic [15:0] word_idx;
   logic [31:0] base_q;
   logic [15:0] count_q;
   logic [31:0] word_q;
   logic        done_q;
   logic        error_q;
   logic [32:0] end_word;
   logic        range_bad;
   logic        byte_acc;
   logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  csum_q;
`endif

   // Range check in 33 bits so base+count cannot wrap past the depth limit.
   assign end_word  = {3'b000, base_addr[31:2]} + {17'd0, word_count};
   assign range_bad = (base_addr[1:0] != 2'b00) || (end_word > 33'(MEM_DEPTH));
   assign last_word = ({1'b0, word_idx} + 17'd1) >= {1'b0, count_q};

`ifdef IMEM_LOADER_CHECKSUM_EN
   assign in_ready = (state == RECV) || (state == CHECK);
`else
   assign in_ready = (state == RECV);
`endif
   assign byte_acc = in_valid && in_ready;
   assign mem_we   = (state == WRITE);
   assign mem_addr = mem_we ? (base_q + {14'd0, word_idx, 2'b00}) : 32'd0;
   assign mem_din  = mem_we ? word_q : 32'd0;
   assign busy     = (state != IDLE);
   assign done     = done_q;
   assign error    = error_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         byte_idx <= 2'd0;
         word_idx <= 16'd0;
         base_q   <= 32'd0;
         count_q  <= 16'd0;
         word_q   <= 32'd0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q   <= 8'd0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (range_bad) begin
                     error_q <= 1'b1;
                  end else begin
                     error_q  <= 1'b0;
                     base_q   <= base_addr;
                     count_q  <= word_count;
                     byte_idx <= 2'd0;
                     word_idx <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                     csum_q   <= 8'd0;
`endif
                     if (word_count == 16'd0) begin
                        done_q <= 1'b1;
                     end else begin
                        state <= RECV;
                     end
                  end
               end
            end
            RECV: begin
               if (byte_acc) begin
                  word_q[{byte_idx, 3'b000} +: 8] <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_q <= csum_q ^ in_data;
`endif
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     state <= WRITE;
                  end
               end
            end
            WRITE: begin
               if (!last_word) begin
                  word_idx <= word_idx + 16'd1;
                  state    <= RECV;
               end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state  <= CHECK;
`else
                  state  <= IDLE;
                  done_q <= 1'b1;
`endif
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
               // done pulses whether or not the trailer matches.
               if (byte_acc) begin
                  error_q <= (in_data != csum_q);
                  done_q  <= 1'b1;
                  state   <= IDLE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
// Build with IMEM_LOADER_CHECKSUM_EN defined to also exercise the trailer checksum.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] base_addr;
   logic [15:0] word_count;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic        busy;
   logic        done;
   logic        error;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [31:0] wr_addr [64];
   logic [31:0] wr_din  [64];
   int          wr_cyc  [64];
   int wr_n = 0;
   int done_n = 0;
   int done_cyc = 0;
   logic [7:0] tb_csum = 8'd0;

   imem_loader #(.MEM_DEPTH(16384)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_din(mem_din), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_we === 1'b1 && wr_n < 64) begin
         wr_addr[wr_n] = mem_addr;
         wr_din[wr_n]  = mem_din;
         wr_cyc[wr_n]  = cyc;
         wr_n++;
      end
      if (done === 1'b1) begin
         done_n++;
         done_cyc = cyc;
      end
   end

   task automatic pulse_start(input logic [31:0] b, input logic [15:0] c);
      start = 1'b1; base_addr = b; word_count = c;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1; in_data = b; n = 0;
      while (in_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         checks++; errors++;
         $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
      end
      tb_csum = tb_csum ^ b;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy !== 1'b0 || done !== 1'b0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++; errors++;
         $display("FAIL wait_idle_timeout: busy=%b required 0", busy);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
      base_addr = 32'd0; word_count = 16'd0;
      repeat (3) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
      checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
      checks++; if (mem_din !== 32'd0) begin errors++; $display("FAIL rst_mem_din: got %h want 0", mem_din); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b want 0", error); end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_after: busy got %b want 0", busy); end
   endtask

   task automatic test_basic();
      logic [7:0] seq [8];
      int w0, d0;
      seq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      w0 = wr_n; d0 = done_n; tb_csum = 8'd0;
      pulse_start(32'h0, 16'd2);
      for (int i = 0; i < 8; i++) send_byte(seq[i], 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(tb_csum, 0);
`endif
      wait_idle();
      checks++; if (wr_n - w0 !== 2) begin errors++; $display("FAIL basic_nwrites: got %0d want 2", wr_n - w0); end
      checks++; if (wr_addr[w0] !== 32'h0) begin errors++; $display("FAIL basic_addr0: got %h want 00000000", wr_addr[w0]); end
      checks++; if (wr_din[w0] !== 32'h00000013) begin errors++; $display("FAIL basic_din0: got %h want 00000013", wr_din[w0]); end
      checks++; if (wr_addr[w0+1] !== 32'h4) begin errors++; $display("FAIL basic_addr1: got %h want 00000004", wr_addr[w0+1]); end
      checks++; if (wr_din[w0+1] !== 32'h00100093) begin errors++; $display("FAIL basic_din1: got %h want 00100093", wr_din[w0+1]); end
      checks++; if (done_n - d0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_n - d0); end
`ifndef IMEM_LOADER_CHECKSUM_EN
      checks++; if (done_cyc !== wr_cyc[w0+1] + 1) begin errors++; $display("FAIL basic_done_timing: got cycle %0d want %0d", done_cyc, wr_cyc[w0+1] + 1); end
`endif
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error: got %b want 0", error); end
   endtask

   task automatic test_misaligned();
      int w0, d0;
      w0 = wr_n; d0 = done_n;
      pulse_start(32'h2, 16'd1);
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL mis_error: got %b want 1", error); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mis_busy: got %b want 0", busy); end
      repeat (3) @(negedge clk);
      checks++; if (wr_n !== w0) begin errors++; $display("FAIL mis_no_write: got %0d writes want 0", wr_n - w0); end
      checks++; if (done_n !== d0) begin errors++; $display("FAIL mis_no_done: got %0d pulses want 0", done_n - d0); end
      pulse_start(32'h0, 16'd0);
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL zero_clears_error: got %b want 0", error); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b want 0", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
   endtask

   task automatic test_bounds();
      int w0, d0;
      w0 = wr_n; d0 = done_n;
      pulse_start(32'h0000FFFC, 16'd2);
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL bound_error: got %b want 1", error); end
      repeat (3) @(negedge clk);
      checks++; if (wr_n !== w0) begin errors++; $display("FAIL bound_no_write: got %0d writes want 0", wr_n - w0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bound_busy: got %b want 0", busy); end
      tb_csum = 8'd0;
      pulse_start(32'h0000FFFC, 16'd1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bound_ok_busy: got %b want 1", busy); end
      send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(tb_csum, 0);
`endif
      wait_idle();
      checks++; if (wr_n - w0 !== 1) begin errors++; $display("FAIL bound_ok_nwrites: got %0d want 1", wr_n - w0); end
      checks++; if (wr_addr[w0] !== 32'h0000FFFC) begin errors++; $display("FAIL bound_ok_addr: got %h want 0000fffc", wr_addr[w0]); end
      checks++; if (wr_din[w0] !== 32'h04030201) begin errors++; $display("FAIL bound_ok_din: got %h want 04030201", wr_din[w0]); end
      checks++; if (done_n - d0 !== 1) begin errors++; $display("FAIL bound_ok_done: got %0d want 1", done_n - d0); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL bound_ok_error: got %b want 0", error); end
   endtask

   task automatic test_gaps_busy();
      logic [7:0] seq [8];
      int gaps [8];
      int w0, d0;
      seq  = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      gaps = '{3, 0, 5, 1, 0, 7, 2, 4};
      w0 = wr_n; d0 = done_n; tb_csum = 8'd0;
      pulse_start(32'h0, 16'd2);
      for (int i = 0; i < 8; i++) begin
         send_byte(seq[i], gaps[i]);
         if (i == 1 || i == 3) begin
            start = 1'b1; base_addr = 32'h40; word_count = 16'd3;
            @(negedge clk);
            start = 1'b0;
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(tb_csum, 2);
`endif
      wait_idle();
      checks++; if (wr_n - w0 !== 2) begin errors++; $display("FAIL gap_nwrites: got %0d want 2", wr_n - w0); end
      checks++; if (wr_addr[w0] !== 32'h0) begin errors++; $display("FAIL gap_addr0: got %h want 00000000", wr_addr[w0]); end
      checks++; if (wr_din[w0] !== 32'h00000013) begin errors++; $display("FAIL gap_din0: got %h want 00000013", wr_din[w0]); end
      checks++; if (wr_addr[w0+1] !== 32'h4) begin errors++; $display("FAIL gap_addr1: got %h want 00000004", wr_addr[w0+1]); end
      checks++; if (wr_din[w0+1] !== 32'h00100093) begin errors++; $display("FAIL gap_din1: got %h want 00100093", wr_din[w0+1]); end
      checks++; if (done_n - d0 !== 1) begin errors++; $display("FAIL gap_done: got %0d want 1", done_n - d0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_busy: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      int w0;
      w0 = wr_n; tb_csum = 8'd0;
      pulse_start(32'h0, 16'd2);
      send_byte(8'h13, 0);
      send_byte(8'h00, 0);
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mid_mem_we: got %b want 0", mem_we); end
      checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL mid_flags: got done=%b error=%b want 0 0", done, error); end
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b1; in_data = 8'h55;
      repeat (12) @(negedge clk);
      in_valid = 1'b0;
      checks++; if (wr_n !== w0) begin errors++; $display("FAIL mid_no_write: got %0d writes want 0", wr_n - w0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle: busy got %b want 0", busy); end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0] seq [8];
      logic [7:0] good;
      int d0;
      seq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      for (int k = 0; k < 2; k++) begin
         d0 = done_n; tb_csum = 8'd0;
         pulse_start(32'h0, 16'd2);
         for (int i = 0; i < 8; i++) send_byte(seq[i], 0);
         good = tb_csum;
         send_byte((k == 0) ? good : 8'h00, 0);
         wait_idle();
         checks++; if (done_n - d0 !== 1) begin errors++; $display("FAIL csum_done_%0d: got %0d want 1", k, done_n - d0); end
         checks++; if (error !== ((k == 0) ? 1'b0 : (good != 8'h00))) begin errors++; $display("FAIL csum_error_%0d: got %b", k, error); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_misaligned();
      test_bounds();
      test_gaps_busy();
      test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
